// File: rtl/demux_1x4.sv
// demux_1x4: registered 1-to-4 demultiplexer with a saturating toggle counter
// on each output and a counter of cycles in which any output toggled.
module demux_1x4 #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [3:0]       a,
  input  logic [1:0]       sel,
  output logic             o0,
  output logic             o1,
  output logic             o2,
  output logic             o3,
  output logic [CNT_W-1:0] tgl0,
  output logic [CNT_W-1:0] tgl1,
  output logic [CNT_W-1:0] tgl2,
  output logic [CNT_W-1:0] tgl3,
  output logic [CNT_W-1:0] tgl_any
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [3:0]       onext_p0;
  logic [3:0]       tgl_p0;
  logic [3:0]       o_p1;
  logic [CNT_W-1:0] cnt_p1 [4];
  logic [CNT_W-1:0] cnt_any_p1;

  // Increment by one when enabled, holding at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                               input logic             en);
    logic [CNT_W-1:0] r;
    r = c;
    if (en && (c != CNT_MAX)) begin
      r = c + CNT_ONE;
    end
    return r;
  endfunction

  // Stage p0: route the selected lane, compare against the registered outputs.
  always_comb begin
    onext_p0      = 4'b0000;
    onext_p0[sel] = a[sel];
    tgl_p0        = onext_p0 ^ o_p1;
  end

  // Stage p1: register outputs and update counters on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_p1       <= 4'b0000;
      cnt_any_p1 <= '0;
      for (int k = 0; k < 4; k++) begin
        cnt_p1[k] <= '0;
      end
    end else begin
      o_p1 <= onext_p0;
      if (clr) begin
        cnt_any_p1 <= '0;
        for (int k = 0; k < 4; k++) begin
          cnt_p1[k] <= '0;
        end
      end else begin
        cnt_any_p1 <= sat_inc(cnt_any_p1, |tgl_p0);
        for (int k = 0; k < 4; k++) begin
          cnt_p1[k] <= sat_inc(cnt_p1[k], tgl_p0[k]);
        end
      end
    end
  end

  assign o0      = o_p1[0];
  assign o1      = o_p1[1];
  assign o2      = o_p1[2];
  assign o3      = o_p1[3];
  assign tgl0    = cnt_p1[0];
  assign tgl1    = cnt_p1[1];
  assign tgl2    = cnt_p1[2];
  assign tgl3    = cnt_p1[3];
  assign tgl_any = cnt_any_p1;

endmodule

// File: tb/tb_demux_1x4.sv
// tb_demux_1x4: directed vector table plus hand sequences for reset and
// saturation, on a default-width instance and a CNT_W=4 instance.
module tb_demux_1x4;

  logic       clk;
  logic       rst;
  logic       clr;
  logic [3:0] a;
  logic [1:0] sel;

  logic        d_o0, d_o1, d_o2, d_o3;
  logic [15:0] d_t0, d_t1, d_t2, d_t3, d_ta;
  logic        q_o0, q_o1, q_o2, q_o3;
  logic [3:0]  q_t0, q_t1, q_t2, q_t3, q_ta;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic       clr;
    logic [1:0] sel;
    logic [3:0] a;
    logic [3:0] eo;
    int         t0, t1, t2, t3, ta;
  } vec_t;

  vec_t vt [10];

  demux_1x4 dut (
    .clk(clk), .rst(rst), .clr(clr), .a(a), .sel(sel),
    .o0(d_o0), .o1(d_o1), .o2(d_o2), .o3(d_o3),
    .tgl0(d_t0), .tgl1(d_t1), .tgl2(d_t2), .tgl3(d_t3), .tgl_any(d_ta)
  );

  demux_1x4 #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .clr(clr), .a(a), .sel(sel),
    .o0(q_o0), .o1(q_o1), .o2(q_o2), .o3(q_o3),
    .tgl0(q_t0), .tgl1(q_t1), .tgl2(q_t2), .tgl3(q_t3), .tgl_any(q_ta)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] eo,
                         input int t0, input int t1, input int t2,
                         input int t3, input int ta);
    chk({tag, " o"},     int'({d_o3, d_o2, d_o1, d_o0}), int'(eo));
    chk({tag, " tgl0"},  int'(d_t0), t0);
    chk({tag, " tgl1"},  int'(d_t1), t1);
    chk({tag, " tgl2"},  int'(d_t2), t2);
    chk({tag, " tgl3"},  int'(d_t3), t3);
    chk({tag, " tgl_any"}, int'(d_ta), ta);
    chk({tag, " o(w4)"}, int'({q_o3, q_o2, q_o1, q_o0}), int'(eo));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    //              clr  sel   a        eo       t0 t1 t2 t3 ta
    vt[0] = '{1'b0, 2'd0, 4'b0101, 4'b0001, 1, 0, 0, 0, 1};
    vt[1] = '{1'b0, 2'd3, 4'b0111, 4'b0000, 2, 0, 0, 0, 2};
    vt[2] = '{1'b0, 2'd2, 4'b0101, 4'b0100, 2, 0, 1, 0, 3};
    vt[3] = '{1'b0, 2'd3, 4'b1101, 4'b1000, 2, 0, 2, 1, 4};
    vt[4] = '{1'b0, 2'd2, 4'b0101, 4'b0100, 2, 0, 3, 2, 5};
    vt[5] = '{1'b0, 2'd0, 4'b0101, 4'b0001, 3, 0, 4, 2, 6};
    vt[6] = '{1'b0, 2'd1, 4'b1101, 4'b0000, 4, 0, 4, 2, 7};
    vt[7] = '{1'b1, 2'd1, 4'b0010, 4'b0010, 0, 0, 0, 0, 0};
    vt[8] = '{1'b0, 2'd1, 4'b0000, 4'b0000, 0, 1, 0, 0, 1};
    vt[9] = '{1'b0, 2'd2, 4'b0100, 4'b0100, 0, 1, 1, 0, 2};

    rst = 1'b1;
    clr = 1'b0;
    sel = 2'd0;
    a   = 4'b0000;
    #2;
    chk_all("reset", 4'b0000, 0, 0, 0, 0, 0);

    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      clr = vt[i].clr;
      sel = vt[i].sel;
      a   = vt[i].a;
      @(posedge clk);
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), vt[i].eo,
              vt[i].t0, vt[i].t1, vt[i].t2, vt[i].t3, vt[i].ta);
      chk($sformatf("vec%0d tgl_any(w4)", i), int'(q_ta), vt[i].ta);
    end
    clr = 1'b0;

    // Asynchronous reset between edges: o2=1 and counters nonzero beforehand.
    #1;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 4'b0000, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_all("rst_held", 4'b0000, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // Saturation: toggle o0 on every edge for 20 edges.
    sel = 2'd0;
    for (int i = 0; i < 20; i++) begin
      a = (i % 2 == 0) ? 4'b0001 : 4'b0000;
      @(posedge clk);
      @(negedge clk);
    end
    chk("sat tgl0(w4)",    int'(q_t0), 15);
    chk("sat tgl_any(w4)", int'(q_ta), 15);
    chk("sat tgl0",        int'(d_t0), 20);
    chk("sat tgl_any",     int'(d_ta), 20);
    chk("sat o0",          int'(d_o0), 0);
    a = 4'b0001;
    @(posedge clk);
    @(negedge clk);
    chk("sat hold tgl0(w4)", int'(q_t0), 15);
    chk("sat hold o0(w4)",   int'(q_o0), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
